// File: rtl/sevenseg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with per-frame input snapshot,
// anti-ghosting blank window and registered active-low outputs.
module sevenseg_scanner #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] display,
    input  logic [7:0]  digit_enable,
    input  logic [7:0]  dp,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic        frame_tick
);

    localparam int unsigned CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          load_pending_q, load_pending_d;
    logic [31:0]   sh_disp_q, sh_disp_d;
    logic [7:0]    sh_de_q, sh_de_d;
    logic [7:0]    sh_dp_q, sh_dp_d;
    logic [7:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          seg_dp_q, seg_dp_d;
    logic          frame_tick_q, frame_tick_d;

    logic          cnt_wrap;
    logic          load;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        // Snapshot at the last cycle of slot 7 so the new frame starts with fresh shadows.
        load     = load_pending_q | (cnt_wrap & (idx_q == 3'd7));

        cnt_d          = cnt_wrap ? '0 : cnt_q + CW'(1);
        idx_d          = cnt_wrap ? idx_q + 3'd1 : idx_q;
        load_pending_d = load_pending_q & ~load;
        sh_disp_d      = load ? display      : sh_disp_q;
        sh_de_d        = load ? digit_enable : sh_de_q;
        sh_dp_d        = load ? dp           : sh_dp_q;
        frame_tick_d   = load;

        nibble   = sh_disp_q[{idx_q, 2'b00} +: 4];
        anode_d  = '1;
        seg_d    = '1;
        seg_dp_d = 1'b1;
        if (cnt_q >= CNT_BLANK) begin
            if (sh_de_q[idx_q] | sh_dp_q[idx_q])
                anode_d = ~(8'h01 << idx_q);
            if (sh_de_q[idx_q])
                seg_d = ~hex7(nibble);
            seg_dp_d = ~sh_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            load_pending_q <= 1'b1;
            sh_disp_q      <= '0;
            sh_de_q        <= '0;
            sh_dp_q        <= '0;
            anode_q        <= '1;
            seg_q          <= '1;
            seg_dp_q       <= 1'b1;
            frame_tick_q   <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            load_pending_q <= load_pending_d;
            sh_disp_q      <= sh_disp_d;
            sh_de_q        <= sh_de_d;
            sh_dp_q        <= sh_dp_d;
            anode_q        <= anode_d;
            seg_q          <= seg_d;
            seg_dp_q       <= seg_dp_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/sevenseg_scanner.md
Name: sevenseg_scanner

Overview:
Sits directly downstream of the seven-segment front end and drives the 8-digit multiplexed common-anode display on the Nexys board. It takes display (8 hex/BCD nibbles), digit_enable and decimal-point bits, and snapshots them once per refresh frame so a frame never shows a mix of old and new values. It scans one digit per slot, inserts an anti-ghosting blank window at the start of each slot, and decodes nibbles to active-low segment patterns.

Parameters:
DIGIT_CYCLES, 100000, clk cycles per digit slot (1 ms at 100 MHz); frame = 8*DIGIT_CYCLES.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range is 1 <= BLANK_CYCLES < DIGIT_CYCLES.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
display  in  32  nibble n (bits 4n+3:4n) drives digit n; digit 0 is rightmost
digit_enable  in  8  bit n=1: digit n shows its segments
dp  in  8  bit n=1: decimal point of digit n lit
anode  out  8  active-low digit select; bit n = digit n
seg  out  7  active-low cathodes; seg[0]=CA ... seg[6]=CG
seg_dp  out  1  active-low decimal-point cathode
frame_tick  out  1  one-cycle pulse when a new frame snapshot is loaded

Behaviour:
- State:
  - cnt: 0..DIGIT_CYCLES-1, increments every cycle and wraps to 0.
  - idx: 0..7, increments when cnt wraps; 7 wraps to 0.
  - load_pending flag.
  - Shadow registers sh_disp[31:0], sh_de[7:0], sh_dp[7:0].
- Reset (resetn=0 at a clk edge):
  - cnt=0, idx=0, shadows=0, load_pending=1.
  - anode=8'hFF, seg=7'h7F, seg_dp=1, frame_tick=0.
  - Reset mid-frame aborts the scan immediately: outputs are blank on the next edge.
- Snapshot: shadows load from the inputs on any cycle where load_pending=1, or where cnt==DIGIT_CYCLES-1 and idx==7.
  - load_pending clears on load.
  - frame_tick is registered: it is 1 in the cycle after the load, and 0 otherwise.
  - Inputs are ignored between snapshots.
- Output stage is registered. In the cycle after internal state (cnt=c, idx=i):
  - If c < BLANK_CYCLES: anode=8'hFF, seg=7'h7F, seg_dp=1.
  - Otherwise:
    - anode = ~(8'h01<<i) if sh_de[i] | sh_dp[i], else 8'hFF.
    - seg = ~decode(sh_disp[4i+3:4i]) if sh_de[i], else 7'h7F.
    - seg_dp = ~sh_dp[i].
- Decode table (active-high, bit0=a..bit6=g):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Timing: the first snapshot is taken in the first cycle after reset release.
  - BLANK_CYCLES >= 1 guarantees slot 0 never displays the pre-load zero shadows.
  - Each digit is lit for DIGIT_CYCLES-BLANK_CYCLES cycles per frame.
- Input changes in the same cycle as a snapshot are captured (sampled at that edge).
- No handshake with upstream. The front end holds display/digit_enable steady between updates; tearing is prevented solely by the frame snapshot.

Test Plan:
(All scenarios use DIGIT_CYCLES=8, BLANK_CYCLES=2; frame = 64 cycles.)
1. Reset:
   - Stimulus: hold resetn=0 for 5 cycles.
   - Required: anode=FF, seg=7F, seg_dp=1, frame_tick=0 throughout; frame_tick=1 exactly once, 2 cycles after release; then a pulse every 64 cycles.
2. Full display:
   - Stimulus: display=0x12345678, digit_enable=FF, dp=00.
   - Required: slot 0 (output cycles 2..7) anode=FE, seg=00 ("8"); slot 7 anode=7F, seg=79 ("1"); slot 4 seg=19 ("4"); during cycles 0..1 of every slot anode=FF.
3. Leading-zero blanking:
   - Stimulus: display=0x00000005, digit_enable=01.
   - Required: slot 0 anode=FE, seg=12; slots 1..7 anode=FF, seg=7F.
4. Decimal point on a disabled digit:
   - Stimulus: dp=04, digit_enable=01.
   - Required: slot 2 anode=FB, seg=7F, seg_dp=0; other slots seg_dp=1.
5. Mid-frame change:
   - Stimulus: display changes from 0x11111111 to 0x22222222 during slot 3.
   - Required: slots 3..7 still show seg=79; the new value (seg=24) appears only from slot 0 of the next frame, coincident with frame_tick.
6. Reset mid-frame:
   - Stimulus: assert resetn=0 during slot 5 with anode=DF.
   - Required: next cycle anode=FF; after release, the scan restarts at slot 0 with a fresh snapshot.
